// File: rtl/taillight_pkg.sv
// Shared grant-state type, sequence lengths and lamp encodings for the tail-light controller.
package taillight_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2,
    HAZ   = 2'd3
  } grant_t;

  localparam int LR_TICKS  = 4;
  localparam int HAZ_TICKS = 2;

  localparam logic [2:0] LRH_IDLE  = 3'b000;
  localparam logic [2:0] LRH_LEFT  = 3'b100;
  localparam logic [2:0] LRH_RIGHT = 3'b010;
  localparam logic [2:0] LRH_HAZ   = 3'b001;

  function automatic logic [2:0] lrh_of(input grant_t g);
    logic [2:0] v;
    case (g)
      IDLE:    v = LRH_IDLE;
      LEFT:    v = LRH_LEFT;
      RIGHT:   v = LRH_RIGHT;
      HAZ:     v = LRH_HAZ;
      default: v = LRH_IDLE;
    endcase
    return v;
  endfunction

  // Hazard wins; left and right together cancel each other out.
  function automatic grant_t arbitrate(input logic l, input logic r, input logic h);
    grant_t g;
    if (h) begin
      g = HAZ;
    end else if (l && !r) begin
      g = LEFT;
    end else if (r && !l) begin
      g = RIGHT;
    end else begin
      g = IDLE;
    end
    return g;
  endfunction

endpackage

// File: rtl/taillight_ctrl_switch_conditioner.sv
// Two-flop synchronizer for one raw switch, followed by an optional stability filter
// enabled by TAILLIGHT_DEBOUNCE_EN.
module switch_conditioner #(
  parameter int DEB_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic sw,
  output logic level
);

  logic meta;
  logic sync;

  // Two-stage synchronizer into the clock domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else begin
      meta <= sw;
      sync <= meta;
    end
  end

`ifdef TAILLIGHT_DEBOUNCE_EN
  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic [CW-1:0] cnt;
  logic          stable;

  // Counts consecutive samples that disagree with the accepted level; any agreeing sample restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= {CW{1'b0}};
      stable <= 1'b0;
    end else if (sync == stable) begin
      cnt <= {CW{1'b0}};
    end else if (cnt == CW'(DEB_CYCLES - 1)) begin
      cnt    <= {CW{1'b0}};
      stable <= sync;
    end else begin
      cnt <= cnt + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  assign level = stable;
`else
  assign level = sync;
`endif

  if (DEB_CYCLES < 1) begin : g_bad_deb
    $error("switch_conditioner: DEB_CYCLES must be at least 1");
  end

endmodule

// File: rtl/taillight_ctrl.sv
// Tail-light command arbiter: enable-tick divider plus left/right/hazard grant sequencing.
// Optional switch debouncing is selected with TAILLIGHT_DEBOUNCE_EN.
module taillight_ctrl
  import taillight_pkg::*;
#(
  parameter int DIV_CYCLES = 12500000,
  parameter int DEB_CYCLES = 500000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       LeftSw,
  input  logic       RightSw,
  input  logic       HazardSw,
  output logic       Enable,
  output logic       L,
  output logic       R,
  output logic       H,
  output logic [1:0] Mode
);

  localparam int DW = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES) : 1;

  logic          left_req;
  logic          right_req;
  logic          haz_req;
  logic [DW-1:0] div_cnt;
  logic [DW-1:0] div_next;
  logic          enable;
  grant_t        state;
  grant_t        state_next;
  logic [1:0]    phase;
  logic [1:0]    phase_next;
  logic          restart;
  logic [2:0]    lrh;

  switch_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_cond_left (
    .clk(Clock), .rst(Reset), .sw(LeftSw), .level(left_req)
  );
  switch_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_cond_right (
    .clk(Clock), .rst(Reset), .sw(RightSw), .level(right_req)
  );
  switch_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_cond_haz (
    .clk(Clock), .rst(Reset), .sw(HazardSw), .level(haz_req)
  );

  // Next divider value, wrapping at the terminal count.
  always_comb begin
    div_next = div_cnt + {{(DW-1){1'b0}}, 1'b1};
    if (div_cnt == DW'(DIV_CYCLES - 1)) begin
      div_next = {DW{1'b0}};
    end else begin
      div_next = div_cnt + {{(DW-1){1'b0}}, 1'b1};
    end
  end

  // Divider and registered strobe: Enable is high exactly while the counter sits at its terminal count.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      div_cnt <= {DW{1'b0}};
      enable  <= 1'b0;
    end else begin
      div_cnt <= div_next;
      enable  <= (div_next == DW'(DIV_CYCLES - 1));
    end
  end

  // Grant next-state: hold a sequence for its length, preempt left/right on hazard.
  always_comb begin
    state_next = state;
    restart    = 1'b0;
    phase_next = phase + 2'd1;
    case (state)
      IDLE: begin
        state_next = arbitrate(left_req, right_req, haz_req);
        restart    = 1'b1;
      end
      LEFT, RIGHT: begin
        if (haz_req) begin
          state_next = HAZ;
          restart    = 1'b1;
        end else if (phase == 2'(LR_TICKS - 1)) begin
          state_next = arbitrate(left_req, right_req, haz_req);
          restart    = 1'b1;
        end else begin
          state_next = state;
          restart    = 1'b0;
        end
      end
      HAZ: begin
        if (phase == 2'(HAZ_TICKS - 1)) begin
          state_next = arbitrate(left_req, right_req, haz_req);
          restart    = 1'b1;
        end else begin
          state_next = state;
          restart    = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
        restart    = 1'b1;
      end
    endcase
    if (restart || (state_next != state)) begin
      phase_next = 2'd0;
    end else begin
      phase_next = phase + 2'd1;
    end
  end

  // Grant, phase and lamp commands advance only on the edge that closes an Enable cycle.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      phase <= 2'd0;
      lrh   <= LRH_IDLE;
    end else if (enable) begin
      state <= state_next;
      phase <= phase_next;
      lrh   <= lrh_of(state_next);
    end
  end

  assign Enable    = enable;
  assign {L, R, H} = lrh;
  assign Mode      = state;

  if (DIV_CYCLES < 2) begin : g_bad_div
    $error("taillight_ctrl: DIV_CYCLES must be at least 2");
  end

endmodule

// File: tb/tb_taillight_ctrl.sv
// Randomized scoreboard bench for taillight_ctrl against a tick-level behavioural model.
module tb_taillight_ctrl;

  localparam int DIV = 4;
  localparam int DEB = 3;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       LeftSw;
  logic       RightSw;
  logic       HazardSw;
  logic       Enable;
  logic       L;
  logic       R;
  logic       H;
  logic [1:0] Mode;

  int compared   = 0;
  int mismatched = 0;

  // Model state: edge count since reset release, switch histories, grant and ticks served.
  int e      = 0;
  int mode   = 0;
  int served = 0;
  bit raw_q[3][$];
  bit deb[3];
  int exp_q[$];

  always #5 Clock = ~Clock;

  taillight_ctrl #(.DIV_CYCLES(DIV), .DEB_CYCLES(DEB)) dut (
    .Clock(Clock), .Reset(Reset), .LeftSw(LeftSw), .RightSw(RightSw), .HazardSw(HazardSw),
    .Enable(Enable), .L(L), .R(R), .H(H), .Mode(Mode)
  );

  function automatic bit raw_at(input int w, input int idx);
    if (idx < 1) return 1'b0;
    return raw_q[w][idx-1];
  endfunction

  function automatic bit window_all(input int w, input int last, input bit v);
    for (int k = last - DEB + 1; k <= last; k++) begin
      if (raw_at(w, k) != v) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic [2:0] lrh_exp(input int m);
    case (m)
      1:       return 3'b100;
      2:       return 3'b010;
      3:       return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  function automatic int choose(input bit l, input bit r, input bit h);
    if (h) return 3;
    if (l && !r) return 1;
    if (r && !l) return 2;
    return 0;
  endfunction

  // Reference model: one step per clock edge, grant decisions only on tick edges.
  initial begin
    bit req[3];
    forever begin
      @(posedge Clock or posedge Reset);
      if (Reset) begin
        e = 0; mode = 0; served = 0;
        for (int w = 0; w < 3; w++) begin raw_q[w].delete(); deb[w] = 1'b0; end
        exp_q.delete();
        exp_q.push_back(0);
      end else begin
        e++;
        raw_q[0].push_back(LeftSw);
        raw_q[1].push_back(RightSw);
        raw_q[2].push_back(HazardSw);
        for (int w = 0; w < 3; w++) begin
`ifdef TAILLIGHT_DEBOUNCE_EN
          req[w] = deb[w];
`else
          req[w] = raw_at(w, e - 2);
`endif
        end
        if (e % DIV == 0) begin
          if (mode == 0) begin
            mode = choose(req[0], req[1], req[2]);
            served = 0;
          end else begin
            served++;
            if ((mode == 1 || mode == 2) && req[2]) begin
              mode = 3; served = 0;
            end else if (served == ((mode == 3) ? 2 : 4)) begin
              mode = choose(req[0], req[1], req[2]);
              served = 0;
            end
          end
          exp_q.push_back(mode);
        end
        for (int w = 0; w < 3; w++) begin
          if (window_all(w, e - 2, 1'b1)) deb[w] = 1'b1;
          else if (window_all(w, e - 2, 1'b0)) deb[w] = 1'b0;
        end
      end
    end
  end

  // Monitor: checks the strobe every cycle and pops an expected grant whenever Enable is presented.
  initial begin
    int exp_mode;
    forever begin
      @(negedge Clock);
      if (Reset) begin
        compared++;
        if ({Enable, Mode, L, R, H} !== 6'b000000) begin
          mismatched++;
          $display("FAIL reset_state: got Enable=%b Mode=%0d LRH=%b%b%b, want all zero", Enable, Mode, L, R, H);
        end
      end else begin
        compared++;
        if (Enable !== ((e % DIV) == DIV - 1)) begin
          mismatched++;
          $display("FAIL enable_strobe: edge %0d got Enable=%b, want %b", e, Enable, (e % DIV) == DIV - 1);
        end
        if (Enable === 1'b1) begin
          compared++;
          if (exp_q.size() == 0) begin
            mismatched++;
            $display("FAIL sb_empty: Enable at edge %0d with no expected grant queued", e);
          end else begin
            exp_mode = exp_q.pop_front();
            if ({Mode, L, R, H} !== {2'(exp_mode), lrh_exp(exp_mode)}) begin
              mismatched++;
              $display("FAIL grant: edge %0d got Mode=%0d LRH=%b%b%b, want Mode=%0d LRH=%b",
                       e, Mode, L, R, H, exp_mode, lrh_exp(exp_mode));
            end
          end
        end
      end
    end
  end

  task automatic hold(input bit l, input bit r, input bit h, input int n);
    LeftSw = l; RightSw = r; HazardSw = h;
    repeat (n) @(negedge Clock);
    #1;
  endtask

  task automatic pulse_reset(input int n);
    Reset = 1'b1;
    repeat (n) @(negedge Clock);
    #1;
    Reset = 1'b0;
  endtask

  // Stimulus: directed scenarios followed by random switch segments.
  initial begin
    Reset = 1'b1; LeftSw = 1'b0; RightSw = 1'b0; HazardSw = 1'b0;
    pulse_reset(3);
    hold(1'b0, 1'b0, 1'b0, 5 * DIV);
    hold(1'b1, 1'b0, 1'b0, 12 * DIV);
    hold(1'b0, 1'b0, 1'b0, 6 * DIV);
    hold(1'b0, 1'b1, 1'b0, 2 * DIV + 1);
    hold(1'b0, 1'b1, 1'b1, 2 * DIV);
    hold(1'b0, 1'b1, 1'b0, 8 * DIV);
    hold(1'b1, 1'b1, 1'b0, 6 * DIV);
    hold(1'b0, 1'b0, 1'b0, 6 * DIV);
    hold(1'b1, 1'b0, 1'b0, 2 * DIV);
    hold(1'b0, 1'b0, 1'b0, 8 * DIV);
    hold(1'b1, 1'b0, 1'b0, 2);
    hold(1'b0, 1'b0, 1'b0, 8 * DIV);
    hold(1'b1, 1'b0, 1'b0, 10);
    hold(1'b0, 1'b0, 1'b0, 8 * DIV);
    hold(1'b1, 1'b0, 1'b0, 7);
    pulse_reset(2);
    hold(1'b0, 1'b0, 1'b0, 3 * DIV);
    for (int i = 0; i < 200; i++) begin
      hold(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) == 0), int'($urandom_range(1, 30)));
    end
    hold(1'b0, 1'b0, 1'b0, 10 * DIV);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
